// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 12-bit instructions and drives
// register-file/ALU control through FETCH/DECODE/EXECUTE/WRITEBACK.
module instr_sequencer #(
    parameter logic [3:0] START_PC = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  instrAddr,
    input  logic [11:0] instrData,
    output logic [1:0]  readAddr1,
    output logic [1:0]  readAddr2,
    output logic [1:0]  writeAddr,
    output logic [1:0]  aluFunc,
    output logic        muxSelect,
    output logic [3:0]  immData,
    output logic        regWrite,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOADI = 2'b01,
        OP_JUMP  = 2'b10,
        OP_HALT  = 2'b11
    } opcode_t;

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    opcode_t     opcode;
    logic        decode_en;

    assign opcode = opcode_t'(ir_q[11:10]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regWrite = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instrData;
                pc_d    = pc_q + 4'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JUMP: begin
                        pc_d    = ir_q[3:0];
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Decoded fields are only presented while an instruction is in flight;
    // outside that window (including reset, where state is IDLE) they read 0.
    assign decode_en = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                       (state_q == S_WRITEBACK);

    always_comb begin
        readAddr1 = '0;
        readAddr2 = '0;
        writeAddr = '0;
        aluFunc   = '0;
        immData   = '0;
        muxSelect = 1'b0;
        if (decode_en) begin
            case (opcode)
                OP_ALU: begin
                    aluFunc   = ir_q[9:8];
                    writeAddr = ir_q[7:6];
                    readAddr1 = ir_q[5:4];
                    readAddr2 = ir_q[3:2];
                    muxSelect = 1'b1;
                end
                OP_LOADI: begin
                    writeAddr = ir_q[7:6];
                    immData   = ir_q[3:0];
                end
                default: ;
            endcase
        end
    end

    assign instrAddr = pc_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted    = (state_q == S_HALTED);

endmodule
